// File: rtl/synth_seq_pkg.sv
// Shared types and constants for the song sequencer: step record layout, FSM states, just-intonation ratio ROM.
package synth_seq_pkg;

  typedef struct packed {
    logic       last;
    logic [2:0] cutoff;
    logic [7:0] length;
    logic [3:0] tone;
  } step_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_PLAY,
    S_DONE
  } seq_state_t;

  localparam logic [31:0] ONE       = 32'h0010_0000;
  localparam int          NUM_TONES = 13;
  localparam logic [3:0]  MAX_TONE  = 4'd12;

  // Q12.20 ratios, truncated: 1, 16/15, 9/8, 6/5, 5/4, 4/3, 45/32, 3/2, 8/5, 5/3, 16/9, 15/8, 2
  localparam logic [31:0] RATIO_ROM [NUM_TONES] = '{
    32'd1048576, 32'd1118481, 32'd1179648, 32'd1258291, 32'd1310720,
    32'd1398101, 32'd1474560, 32'd1572864, 32'd1677721, 32'd1747626,
    32'd1864135, 32'd1966080, 32'd2097152
  };

  function automatic logic [3:0] clamp_tone(input logic [3:0] tone);
    return (tone > MAX_TONE) ? MAX_TONE : tone;
  endfunction

endpackage

// File: rtl/note_freq_calc.sv
// Registered tone -> Q12.20 note frequency (ratio lookup times base, >> 20). One cycle latency, loads only when i_en.
// No backpressure: the result holds until the next enabled cycle.
module note_freq_calc
  import synth_seq_pkg::*;
#(
  parameter logic [31:0] BASE_FREQ = 32'd110 << 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [3:0]  i_tone,
  output logic [31:0] o_note
);

  logic [63:0] w_prod;
  logic [31:0] w_note;

  assign w_prod = {32'd0, BASE_FREQ} * {32'd0, RATIO_ROM[clamp_tone(i_tone)]};
  assign w_note = 32'(w_prod >> 20);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_note <= '0;
    end else if (i_en) begin
      o_note <= w_note;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Plays a programmed step table onto the synth voices; start-to-sound 3 cycles, 2-cycle LOAD/CALC gap between steps.
// Outputs hold through the gap; table writes are accepted only while idle.
module song_sequencer
  import synth_seq_pkg::*;
#(
  parameter int          NUM_VOICES     = 8,
  parameter int          STEPS          = 16,
  parameter int          TICKS_PER_UNIT = 12000,
  parameter logic [31:0] BASE_FREQ      = 32'd110 << 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(STEPS)-1:0] wr_addr,
  input  logic [15:0]              wr_data,
  output logic [NUM_VOICES*32-1:0] frequencies,
  output logic [NUM_VOICES*32-1:0] voice_volumes,
  output logic [2:0]               cutoff,
  output logic                     busy,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     done
);

  localparam int IDX_W = $clog2(STEPS);

  seq_state_t       r_state;
  seq_state_t       w_next;
  step_t            r_table [STEPS];
  step_t            w_rd;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [2:0]       r_cut_step;
  logic             r_last;
  logic [31:0]      r_cnt;
  logic [31:0]      r_note;
  logic [31:0]      r_vol;
  logic [2:0]       r_cutoff;
  logic [31:0]      w_calc_note;
  logic             w_at_end;
  logic             w_load;
  logic             w_play;
  logic             w_idx0;
  logic             w_idx_inc;
  logic             w_vol_clr;

  // Table is plain RAM: no reset, written only while idle so a playing song cannot change under us.
  always_ff @(posedge clk) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_table[wr_addr] <= step_t'(wr_data);
    end
  end

  assign w_rd     = r_table[r_idx];
  assign w_at_end = (r_idx == IDX_W'(STEPS - 1));

  note_freq_calc #(
    .BASE_FREQ (BASE_FREQ)
  ) u_calc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_load),
    .i_tone (w_rd.tone),
    .o_note (w_calc_note)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_play    = 1'b0;
    w_idx0    = 1'b0;
    w_idx_inc = 1'b0;
    w_vol_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOAD;
          w_idx0 = 1'b1;
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_next    = S_IDLE;
          w_vol_clr = 1'b1;
        end else if (w_rd.length == 8'd0) begin
          if (w_rd.last || w_at_end) begin
            w_next    = S_DONE;
            w_vol_clr = 1'b1;
          end else begin
            w_idx_inc = 1'b1;
          end
        end else begin
          w_next = S_CALC;
          w_load = 1'b1;
        end
      end
      S_CALC: begin
        if (stop) begin
          w_next    = S_IDLE;
          w_vol_clr = 1'b1;
        end else begin
          w_next = S_PLAY;
          w_play = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_next    = S_IDLE;
          w_vol_clr = 1'b1;
        end else if (sample_tick && (r_cnt == '0)) begin
          if (r_last || w_at_end) begin
            w_next    = S_DONE;
            w_vol_clr = 1'b1;
          end else begin
            w_next    = S_LOAD;
            w_idx_inc = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_len      <= '0;
      r_cut_step <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_note     <= '0;
      r_vol      <= '0;
      r_cutoff   <= '0;
    end else begin
      if (w_idx0) begin
        r_idx <= '0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_load) begin
        r_len      <= w_rd.length;
        r_cut_step <= w_rd.cutoff;
        r_last     <= w_rd.last;
      end
      // Counter ends at 0 so the L*TICKS_PER_UNIT-th tick is the one that advances.
      if (r_state == S_CALC) begin
        r_cnt <= 32'(r_len) * 32'(TICKS_PER_UNIT) - 32'd1;
      end else if ((r_state == S_PLAY) && sample_tick && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 32'd1;
      end
      if (w_play) begin
        r_note   <= w_calc_note;
        r_cutoff <= r_cut_step;
        r_vol    <= ONE;
      end else if (w_vol_clr) begin
        r_vol <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign frequencies[gi*32 +: 32]   = r_note << (gi % 3);
    assign voice_volumes[gi*32 +: 32] = r_vol;
  end

  assign cutoff   = r_cutoff;
  assign busy     = (r_state != S_IDLE);
  assign step_idx = r_idx;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a queue of expected note outputs, popped at each PLAY entry.
module tb_song_sequencer;

  localparam int NV  = 8;
  localparam int TPU = 4;
  localparam logic [31:0] ONE_Q = 32'd1048576;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [15:0]   wr_data = '0;
  logic [NV*32-1:0] frequencies;
  logic [NV*32-1:0] voice_volumes;
  logic [2:0]    cutoff;
  logic          busy;
  logic [3:0]    step_idx;
  logic          done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] note;
    logic [2:0]  cut;
    logic [3:0]  idx;
  } exp_t;
  exp_t sb[$];

  int RN [13] = '{1, 16, 9, 6, 5, 4, 45, 3, 8, 5, 16, 15, 2};
  int RD [13] = '{1, 15, 8, 5, 4, 3, 32, 2, 5, 3, 9, 8, 1};

  song_sequencer #(
    .NUM_VOICES     (NV),
    .STEPS          (16),
    .TICKS_PER_UNIT (TPU),
    .BASE_FREQ      (32'd110 << 20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_tick   (sample_tick),
    .start         (start),
    .stop          (stop),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes),
    .cutoff        (cutoff),
    .busy          (busy),
    .step_idx      (step_idx),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr_step(input int addr, input bit last, input int cut, input int len, input int tone);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = {last, 3'(cut), 8'(len), 4'(tone)};
    cyc();
    wr_en   = 1'b0;
  endtask

  task automatic push_note(input int tone, input int cut, input int idx);
    exp_t e;
    int   t;
    t      = (tone > 12) ? 12 : tone;
    e.note = 32'(110 * ((64'd1048576 * 64'(RN[t])) / 64'(RD[t])));
    e.cut  = 3'(cut);
    e.idx  = 4'(idx);
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic one_tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic ticks(input int k);
    repeat (k) begin
      one_tick();
      cyc();
    end
  endtask

  task automatic check_play(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i < NV; i++) begin
        chk($sformatf("%s_freq%0d", tag, i), frequencies[i*32 +: 32], e.note << (i % 3));
      end
      chk({tag, "_vol0"}, voice_volumes[31:0], ONE_Q);
      chk({tag, "_vol7"}, voice_volumes[NV*32-1 -: 32], ONE_Q);
      chk({tag, "_cutoff"}, 32'(cutoff), 32'(e.cut));
      chk({tag, "_idx"}, 32'(step_idx), 32'(e.idx));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  initial begin
    // reset values
    cyc();
    chk("rst_freq0", frequencies[31:0], 32'd0);
    chk("rst_freq7", frequencies[NV*32-1 -: 32], 32'd0);
    chk("rst_vol0", voice_volumes[31:0], 32'd0);
    chk("rst_cutoff", 32'(cutoff), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(step_idx), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    cyc();

    // single note, tone 0, length 2 -> 8 ticks
    wr_step(0, 1'b1, 1, 2, 0);
    push_note(0, 1, 0);
    pulse_start();
    chk("t1_busy_load", 32'(busy), 32'd1);
    chk("t1_vol_load", voice_volumes[31:0], 32'd0);
    cyc();
    chk("t1_vol_calc", voice_volumes[31:0], 32'd0);
    cyc();
    check_play("t1");
    chk("t1_freq0_const", frequencies[31:0], 32'd115343360);
    chk("t1_freq2_const", frequencies[95:64], 32'd461373440);
    ticks(7);
    chk("t1_done_early", 32'(done), 32'd0);
    chk("t1_vol_early", voice_volumes[31:0], ONE_Q);
    one_tick();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_vol_done", voice_volumes[31:0], 32'd0);
    cyc();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_freq_hold", frequencies[31:0], 32'd115343360);

    // two steps: tone 7 then tone 12, with the 2-cycle gap
    wr_step(0, 1'b0, 2, 1, 7);
    wr_step(1, 1'b1, 3, 1, 12);
    push_note(7, 2, 0);
    push_note(12, 3, 1);
    pulse_start();
    cyc();
    cyc();
    check_play("t2s0");
    chk("t2_freq0_const", frequencies[31:0], 32'd173015040);
    ticks(TPU - 1);
    one_tick();
    chk("t2_gap1_freq", frequencies[31:0], 32'd173015040);
    chk("t2_gap1_vol", voice_volumes[31:0], ONE_Q);
    cyc();
    chk("t2_gap2_freq", frequencies[31:0], 32'd173015040);
    chk("t2_gap2_vol", voice_volumes[31:0], ONE_Q);
    cyc();
    check_play("t2s1");
    chk("t2_freq1_const", frequencies[31:0], 32'd230686720);
    ticks(TPU - 1);
    one_tick();
    chk("t2_done", 32'(done), 32'd1);
    cyc();

    // tone clamp and length-0 skip
    wr_step(0, 1'b0, 4, 1, 15);
    wr_step(1, 1'b0, 6, 0, 3);
    wr_step(2, 1'b1, 5, 1, 5);
    push_note(15, 4, 0);
    push_note(5, 5, 2);
    pulse_start();
    cyc();
    cyc();
    check_play("t3s0");
    chk("t3_clamp_const", frequencies[31:0], 32'd230686720);
    ticks(TPU - 1);
    one_tick();
    chk("t3_skip_freq_a", frequencies[31:0], 32'd230686720);
    cyc();
    chk("t3_skip_freq_b", frequencies[31:0], 32'd230686720);
    chk("t3_skip_cut", 32'(cutoff), 32'd4);
    cyc();
    chk("t3_calc_vol", voice_volumes[31:0], ONE_Q);
    cyc();
    check_play("t3s2");
    ticks(TPU - 1);
    one_tick();
    chk("t3_done", 32'(done), 32'd1);
    cyc();

    // stop on the 3rd tick of a 16-tick note
    wr_step(0, 1'b0, 6, 4, 4);
    wr_step(1, 1'b1, 2, 1, 9);
    push_note(4, 6, 0);
    pulse_start();
    cyc();
    cyc();
    check_play("t4a");
    ticks(2);
    sample_tick = 1'b1;
    stop = 1'b1;
    cyc();
    sample_tick = 1'b0;
    stop = 1'b0;
    chk("t4_stop_busy", 32'(busy), 32'd0);
    chk("t4_stop_vol", voice_volumes[31:0], 32'd0);
    chk("t4_stop_done", 32'(done), 32'd0);
    cyc();
    chk("t4_stop_done2", 32'(done), 32'd0);

    // replay from step 0; write and start while busy are ignored
    push_note(4, 6, 0);
    push_note(9, 2, 1);
    pulse_start();
    cyc();
    cyc();
    check_play("t5s0");
    ticks(4 * TPU - 1);
    one_tick();
    cyc();
    cyc();
    check_play("t5s1");
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_data = {1'b1, 3'd0, 8'd1, 4'd0};
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    chk("t5_busy_start_idx", 32'(step_idx), 32'd1);
    chk("t5_busy_start_busy", 32'(busy), 32'd1);
    ticks(TPU - 1);
    one_tick();
    chk("t5_done", 32'(done), 32'd1);
    cyc();

    push_note(4, 6, 0);
    pulse_start();
    cyc();
    cyc();
    check_play("t6_readback");
    ticks(1);

    // asynchronous reset mid-note
    rst_n = 1'b0;
    #1;
    chk("t7_rst_freq0", frequencies[31:0], 32'd0);
    chk("t7_rst_freq2", frequencies[95:64], 32'd0);
    chk("t7_rst_vol", voice_volumes[31:0], 32'd0);
    chk("t7_rst_cutoff", 32'(cutoff), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_idx", 32'(step_idx), 32'd0);
    chk("t7_rst_done", 32'(done), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    wr_step(0, 1'b1, 7, 1, 2);
    push_note(2, 7, 0);
    pulse_start();
    cyc();
    cyc();
    check_play("t7_after");
    ticks(TPU - 1);
    one_tick();
    chk("t7_done", 32'(done), 32'd1);
    chk("t7_sb_empty", 32'(sb.size()), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
